mod_counter: RTL and testbench
==============================

// Module: mod_counter
//
// PURPOSE
//   Parametrised modulo-N up/down counter; next generation of the fixed 6-bit
//   T-flip-flop ripple-enable counter. Adds width/modulus parameters,
//   direction control, count enable, parallel load, and wrap or saturate mode.
//   Adds a registered one-cycle boundary pulse for cascading or
//   timebase generation. Used wherever the design needs a programmable
//   divider or position counter.
//
// PARAMETERS
//   WIDTH     6   count width in bits; 1 <= WIDTH <= 32
//   MODULUS   64  count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//   SATURATE  0   0 = wrap at boundaries, 1 = hold at boundaries
//
// PORTS
//   clock       in   1      rising-edge clock; sole clock of the block
//   reset       in   1      synchronous, active-low reset
//   enable      in   1      count enable; 1 = step one position this cycle
//   up          in   1      direction; 1 = increment, 0 = decrement
//   load        in   1      parallel load strobe
//   load_value  in   WIDTH  value captured on load
//   count       out  WIDTH  current count, registered
//   at_limit    out  1      comb: count == MODULUS-1 when up=1, count == 0 when up=0
//   rollover    out  1      registered one-cycle pulse, boundary event last cycle
//
// BEHAVIOUR
//   - All state updates on rising clock edge only.
//   - Per edge, priority is: reset low > load > enable > hold.
//   - reset low at edge: count <= 0, rollover <= 0; load and enable ignored.
//   - load=1: count <= load_value when load_value < MODULUS.
//     Otherwise count <= MODULUS-1 (clamp). rollover <= 0 and enable is ignored.
//   - enable=1 and up=1:
//     - count < MODULUS-1: count <= count+1, rollover <= 0.
//     - count == MODULUS-1, SATURATE=0: count <= 0, rollover <= 1.
//     - count == MODULUS-1, SATURATE=1: count holds, rollover <= 1.
//   - enable=1 and up=0:
//     - count > 0: count <= count-1, rollover <= 0.
//     - count == 0, SATURATE=0: count <= MODULUS-1, rollover <= 1.
//     - count == 0, SATURATE=1: count holds, rollover <= 1.
//   - enable=0 (no load): count holds, rollover <= 0.
//     rollover never stays high more than 1 cycle unless the boundary is
//     re-crossed (saturate: stays high while enable held at limit).
//   - Latency: count reflects a step/load one edge after the strobe.
//     rollover rises on the same edge as the wrapping count update.
//   - Direction may change on any cycle; takes effect on that cycle's step.
//   - at_limit is purely combinational from count and up; no enable gating.
//   - Arithmetic is modulo MODULUS, not 2**WIDTH. count never leaves 0..MODULUS-1,
//     including after load; no intermediate value is ever presented.
//   - MODULUS == 2**WIDTH: wrap compare still explicit; behaves as a plain
//     binary counter (WIDTH=6, MODULUS=64 matches the previous counter when
//     up=1 and enable=1).
//   - Reset mid-count: next edge forces 0 regardless of other inputs;
//     counting resumes on the first edge with reset high.
//   - Out-of-range parameters: elaboration-time error (generate-time check).
//
// TESTING  (bench A: WIDTH=6 MODULUS=64 SATURATE=0;
//           bench B: WIDTH=4 MODULUS=10 SATURATE=0/1)
//   1. A: reset low 2 cycles, then enable=1 up=1 for 64 edges ->
//      count 0,1..63,0; rollover=1 only in the cycle count returns to 0;
//      at_limit=1 only while count=63.
//   2. B wrap: from reset, enable=1 up=0 -> count 9 with rollover=1;
//      continue -> 8,7.. with rollover=0.
//   3. B saturate: load 8, enable=1 up=1 for 3 edges -> count 9,9,9;
//      rollover 0,1,1; deassert enable -> rollover 0 next edge.
//   4. B: load=1 load_value=12 -> count 9; load_value=5 with enable=1 up=1
//      same edge -> count 5, not 6.
//   5. A: count at 37, reset low with load=1 and enable=1 -> count 0 and
//      rollover 0 next edge; reset high -> 1,2,3 on following edges.
//   6. B wrap: count 9 up=1 enable=1, flip up=0 same cycle -> count 8 and
//      rollover 0 (direction applied in-cycle).

Source files
------------

// File: rtl/mod_counter.sv
// mod_counter: parametrised modulo-N up/down counter with parallel load,
// wrap or saturate behaviour at the boundaries, a combinational at_limit
// flag and a registered one-cycle rollover pulse for cascading.
module mod_counter #(
   parameter int WIDTH    = 6,
   parameter int MODULUS  = 64,
   parameter int SATURATE = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             at_limit,
   output logic             rollover
);

   // Reject parameter sets the counter cannot represent.
   generate
      if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
         $error("mod_counter: WIDTH must be in 1..32");
      end
      if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
         $error("mod_counter: MODULUS must be in 2..2**WIDTH");
      end
      if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
         $error("mod_counter: SATURATE must be 0 or 1");
      end
   endgenerate

   // Top of the count range; the wrap compare is explicit even when
   // MODULUS == 2**WIDTH so the counter never relies on binary overflow.
   localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
   localparam bit               SAT       = (SATURATE != 0);

   logic [WIDTH-1:0] next_count;
   logic             next_rollover;

   // Next-state selection: load beats enable, enable beats hold.
   always_comb begin
      next_count    = count;
      next_rollover = 1'b0;
      if (load) begin
         // Out-of-range load values clamp to the top of the range.
         next_count = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
      end else if (enable) begin
         if (up) begin
            if (count == MAX_COUNT) begin
               next_count    = SAT ? count : '0;
               next_rollover = 1'b1;
            end else begin
               next_count = count + 1'b1;
            end
         end else begin
            if (count == '0) begin
               next_count    = SAT ? count : MAX_COUNT;
               next_rollover = 1'b1;
            end else begin
               next_count = count - 1'b1;
            end
         end
      end
   end

   // State register with synchronous active-low reset taking top priority.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count    <= '0;
         rollover <= 1'b0;
      end else begin
         count    <= next_count;
         rollover <= next_rollover;
      end
   end

   // Boundary flag follows the current direction, not gated by enable.
   always_comb begin
      at_limit = up ? (count == MAX_COUNT) : (count == '0);
   end

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: three instances (6-bit/64 wrap,
// 4-bit/10 wrap, 4-bit/10 saturate) driven by directed vectors. The
// stimulus process queues hand-computed expectations; a monitor pops and
// compares them one tick after every rising edge.
module tb_mod_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A: WIDTH=6 MODULUS=64 wrap
   logic       a_rst = 1'b0, a_en = 1'b0, a_up = 1'b1, a_ld = 1'b0;
   logic [5:0] a_lv = '0, a_count;
   logic       a_lim, a_roll;
   // instance B: WIDTH=4 MODULUS=10 wrap
   logic       b_rst = 1'b0, b_en = 1'b0, b_up = 1'b1, b_ld = 1'b0;
   logic [3:0] b_lv = '0, b_count;
   logic       b_lim, b_roll;
   // instance S: WIDTH=4 MODULUS=10 saturate
   logic       s_rst = 1'b0, s_en = 1'b0, s_up = 1'b1, s_ld = 1'b0;
   logic [3:0] s_lv = '0, s_count;
   logic       s_lim, s_roll;

   mod_counter #(.WIDTH(6), .MODULUS(64), .SATURATE(0)) dut_a (
      .clock(clk), .reset(a_rst), .enable(a_en), .up(a_up), .load(a_ld),
      .load_value(a_lv), .count(a_count), .at_limit(a_lim), .rollover(a_roll));
   mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_b (
      .clock(clk), .reset(b_rst), .enable(b_en), .up(b_up), .load(b_ld),
      .load_value(b_lv), .count(b_count), .at_limit(b_lim), .rollover(b_roll));
   mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
      .clock(clk), .reset(s_rst), .enable(s_en), .up(s_up), .load(s_ld),
      .load_value(s_lv), .count(s_count), .at_limit(s_lim), .rollover(s_roll));

   typedef struct {
      int id;
      int cnt;
      bit roll;
      bit lim;
      int seq;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   seq_no = 0;

   // Drive one instance's inputs for the coming edge and queue the state
   // expected after that edge. at_limit is given explicitly per vector.
   task automatic drive(input int id, input bit rst, input bit ld, input int lv,
                        input bit en, input bit u, input int ecnt, input bit eroll,
                        input bit elim);
      exp_t e;
      case (id)
         0: begin a_rst = rst; a_ld = ld; a_lv = 6'(lv); a_en = en; a_up = u; end
         1: begin b_rst = rst; b_ld = ld; b_lv = 4'(lv); b_en = en; b_up = u; end
         default: begin s_rst = rst; s_ld = ld; s_lv = 4'(lv); s_en = en; s_up = u; end
      endcase
      e.id = id; e.cnt = ecnt; e.roll = eroll; e.lim = elim; e.seq = seq_no;
      seq_no++;
      q.push_back(e);
   endtask

   // Monitor: after each rising edge compare every queued expectation.
   initial begin
      exp_t e;
      int   ac;
      bit   ar, al;
      forever begin
         @(posedge clk);
         #1;
         while (q.size() > 0) begin
            e = q.pop_front();
            case (e.id)
               0: begin ac = int'(a_count); ar = a_roll; al = a_lim; end
               1: begin ac = int'(b_count); ar = b_roll; al = b_lim; end
               default: begin ac = int'(s_count); ar = s_roll; al = s_lim; end
            endcase
            checks++;
            if (ac != e.cnt) begin
               errors++;
               $display("FAIL count dut%0d vec%0d: got %0d want %0d", e.id, e.seq, ac, e.cnt);
            end
            checks++;
            if (ar != e.roll) begin
               errors++;
               $display("FAIL rollover dut%0d vec%0d: got %0b want %0b", e.id, e.seq, ar, e.roll);
            end
            checks++;
            if (al != e.lim) begin
               errors++;
               $display("FAIL at_limit dut%0d vec%0d: got %0b want %0b", e.id, e.seq, al, e.lim);
            end
         end
      end
   end

   // Stimulus: inputs change on the falling edge only.
   initial begin
      @(negedge clk);
      // reset all instances for two edges
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 1, 5, 1, 1, 0, 0, 0);
         drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
         drive(2, 0, 0, 0, 1, 0, 0, 0, 1);
         @(negedge clk);
      end
      b_rst = 1'b1; b_en = 1'b0; s_rst = 1'b1; s_en = 1'b0;

      // A: 64 up steps, 1..63 then wrap to 0 with rollover
      for (int k = 1; k <= 64; k++) begin
         drive(0, 1, 0, 0, 1, 1, k % 64, k == 64, k == 63);
         @(negedge clk);
      end
      // A: rollover clears when enable drops
      drive(0, 1, 0, 0, 0, 1, 0, 0, 0); @(negedge clk);
      // A: down from 0 wraps to 63
      drive(0, 1, 0, 0, 1, 0, 63, 1, 0); @(negedge clk);
      // A: load 37, then reset with load+enable -> 0, then 1,2,3
      drive(0, 1, 1, 37, 0, 1, 37, 0, 0); @(negedge clk);
      drive(0, 0, 1, 5,  1, 1, 0,  0, 0); @(negedge clk);
      drive(0, 1, 0, 0,  1, 1, 1,  0, 0); @(negedge clk);
      drive(0, 1, 0, 0,  1, 1, 2,  0, 0); @(negedge clk);
      drive(0, 1, 0, 0,  1, 1, 3,  0, 0); @(negedge clk);
      a_en = 1'b0;

      // B wrap: down from 0 -> 9 with rollover, then 8, 7
      drive(1, 1, 0, 0, 1, 0, 9, 1, 0); @(negedge clk);
      drive(1, 1, 0, 0, 1, 0, 8, 0, 0); @(negedge clk);
      drive(1, 1, 0, 0, 1, 0, 7, 0, 0); @(negedge clk);
      // B: load 9, then step with up flipped to 0 -> 8, no rollover
      drive(1, 1, 1, 9, 0, 1, 9, 0, 1); @(negedge clk);
      drive(1, 1, 0, 0, 1, 0, 8, 0, 0); @(negedge clk);
      // B: up wrap 9 -> 0
      drive(1, 1, 1, 9, 0, 1, 9, 0, 1); @(negedge clk);
      drive(1, 1, 0, 0, 1, 1, 0, 1, 0); @(negedge clk);
      // B: out-of-range load clamps to 9; load beats enable; hold
      drive(1, 1, 1, 12, 0, 1, 9, 0, 1); @(negedge clk);
      drive(1, 1, 1, 5,  1, 1, 5, 0, 0); @(negedge clk);
      drive(1, 1, 0, 0,  0, 1, 5, 0, 0); @(negedge clk);
      // B: load 15 (max 4-bit value) also clamps
      drive(1, 1, 1, 15, 0, 0, 9, 0, 0); @(negedge clk);
      b_en = 1'b0;

      // S: load 8, up x3 -> 9,9,9 rollover 0,1,1; drop enable -> 0
      drive(2, 1, 1, 8, 0, 1, 8, 0, 0); @(negedge clk);
      drive(2, 1, 0, 0, 1, 1, 9, 0, 1); @(negedge clk);
      drive(2, 1, 0, 0, 1, 1, 9, 1, 1); @(negedge clk);
      drive(2, 1, 0, 0, 1, 1, 9, 1, 1); @(negedge clk);
      drive(2, 1, 0, 0, 0, 1, 9, 0, 1); @(negedge clk);
      // S: load 1, down -> 0, then hold at 0 with rollover
      drive(2, 1, 1, 1, 0, 0, 1, 0, 0); @(negedge clk);
      drive(2, 1, 0, 0, 1, 0, 0, 0, 1); @(negedge clk);
      drive(2, 1, 0, 0, 1, 0, 0, 1, 1); @(negedge clk);
      // S: reset while saturated clears rollover
      drive(2, 0, 0, 0, 1, 0, 0, 0, 1); @(negedge clk);
      s_en = 1'b0;

      @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
